// File: rtl/rect_rasterizer.sv
`timescale 1ns/1ps
// rect_rasterizer: walks every pixel of an axis-aligned filled rectangle in
// row-major order and drives the frame-buffer datapath rasterizer port.
// Build option: define RECT_RASTERIZER_ZTEST_EN to enable the per-pixel
// Z test (read-modify-write, one DRAIN cycle); undefined gives plain fills.
module rect_rasterizer #(
    parameter int unsigned HORIZ_RESOLUTION = 80,
    parameter int unsigned VERT_RESOLUTION  = 60,
    parameter int unsigned COLOR_DEPTH      = 12,
    parameter int unsigned Z_DEPTH          = 2,
    localparam int unsigned XW   = $clog2(HORIZ_RESOLUTION),
    localparam int unsigned YW   = $clog2(VERT_RESOLUTION),
    localparam int unsigned FB_W = COLOR_DEPTH + Z_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_srst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [XW-1:0]          i_cmd_x0,
    input  logic [XW-1:0]          i_cmd_x1,
    input  logic [YW-1:0]          i_cmd_y0,
    input  logic [YW-1:0]          i_cmd_y1,
    input  logic [COLOR_DEPTH-1:0] i_cmd_color,
    input  logic [Z_DEPTH-1:0]     i_cmd_z,
    output logic                   o_raster_in_progress,
    output logic [XW-1:0]          o_fb_horiz_write_addr,
    output logic [YW-1:0]          o_fb_vert_write_addr,
    output logic                   o_fb_write_en,
    output logic [FB_W-1:0]        o_fb_write_pixel_data,
    output logic [XW-1:0]          o_fb_horiz_read_addr,
    output logic [YW-1:0]          o_fb_vert_read_addr,
    input  logic [FB_W-1:0]        i_fb_read_pixel_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_e;

`ifdef RECT_RASTERIZER_ZTEST_EN
    localparam state_e ST_AFTER_SCAN = ST_DRAIN;
`else
    localparam state_e ST_AFTER_SCAN = ST_IDLE;
`endif

    state_e                 state_q, state_d;
    logic [XW-1:0]          x0_q, x0_d, x1_q, x1_d, x_q, x_d;
    logic [YW-1:0]          y0_q, y0_d, y1_q, y1_d, y_q, y_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    logic [Z_DEPTH-1:0]     z_q, z_d;
    logic                   ready_q, busy_q;
    logic                   accept_c, empty_c;
    logic [XW-1:0]          x1_clip_c;
    logic [YW-1:0]          y1_clip_c;
    logic                   unused_rd_c;

    // Ready is held high through reset and masked so it rises the first cycle after release
    assign o_cmd_ready          = ready_q && !i_srst;
    assign o_raster_in_progress = busy_q;
    assign unused_rd_c          = ^i_fb_read_pixel_data;

    // Next-state: command capture with clipping, row-major pixel walk
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        z_d       = z_q;
        empty_c   = 1'b0;
        accept_c  = i_cmd_valid && o_cmd_ready && (state_q == ST_IDLE);
        x1_clip_c = (i_cmd_x1 > XW'(HORIZ_RESOLUTION - 1)) ? XW'(HORIZ_RESOLUTION - 1) : i_cmd_x1;
        y1_clip_c = (i_cmd_y1 > YW'(VERT_RESOLUTION - 1)) ? YW'(VERT_RESOLUTION - 1) : i_cmd_y1;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    // Clipped x1/y1 are in range, so an out-of-range x0/y0 also lands here
                    if ((i_cmd_x0 > x1_clip_c) || (i_cmd_y0 > y1_clip_c)) begin
                        empty_c = 1'b1;
                    end else begin
                        x0_d    = i_cmd_x0;
                        x1_d    = x1_clip_c;
                        y0_d    = i_cmd_y0;
                        y1_d    = y1_clip_c;
                        x_d     = i_cmd_x0;
                        y_d     = i_cmd_y0;
                        color_d = i_cmd_color;
                        z_d     = i_cmd_z;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (x_q == x1_q) begin
                    if (y_q == y1_q) begin
                        state_d = ST_AFTER_SCAN;
                    end else begin
                        x_d = x0_q;
                        y_d = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and command registers
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE) || empty_c;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            z_q     <= z_d;
        end
    end

`ifdef RECT_RASTERIZER_ZTEST_EN
    logic [XW-1:0] rd_x_q, pend_x_q;
    logic [YW-1:0] rd_y_q, pend_y_q;
    logic          pend_q;
    logic          z_pass_c;

    // Read address leads the write by one cycle; the pending pixel waits for read data
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            pend_q   <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
        end else begin
            rd_x_q   <= (state_d == ST_SCAN) ? x_d : '0;
            rd_y_q   <= (state_d == ST_SCAN) ? y_d : '0;
            pend_q   <= (state_q == ST_SCAN);
            pend_x_q <= (state_q == ST_SCAN) ? x_q : '0;
            pend_y_q <= (state_q == ST_SCAN) ? y_q : '0;
        end
    end

    // Write only where the new depth is at least the stored depth
    assign z_pass_c              = pend_q && (z_q >= i_fb_read_pixel_data[FB_W-1:COLOR_DEPTH]);
    assign o_fb_write_en         = z_pass_c;
    assign o_fb_horiz_write_addr = z_pass_c ? pend_x_q : '0;
    assign o_fb_vert_write_addr  = z_pass_c ? pend_y_q : '0;
    assign o_fb_write_pixel_data = z_pass_c ? {z_q, color_q} : '0;
    assign o_fb_horiz_read_addr  = rd_x_q;
    assign o_fb_vert_read_addr   = rd_y_q;
`else
    logic            wr_en_q;
    logic [XW-1:0]   wr_x_q;
    logic [YW-1:0]   wr_y_q;
    logic [FB_W-1:0] wr_data_q;

    // Unconditional fill: the write is issued in the scan cycle of its pixel
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            wr_en_q   <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= (state_d == ST_SCAN);
            wr_x_q    <= (state_d == ST_SCAN) ? x_d : '0;
            wr_y_q    <= (state_d == ST_SCAN) ? y_d : '0;
            wr_data_q <= (state_d == ST_SCAN) ? {z_d, color_d} : '0;
        end
    end

    assign o_fb_write_en         = wr_en_q;
    assign o_fb_horiz_write_addr = wr_x_q;
    assign o_fb_vert_write_addr  = wr_y_q;
    assign o_fb_write_pixel_data = wr_data_q;
    assign o_fb_horiz_read_addr  = '0;
    assign o_fb_vert_read_addr   = '0;
`endif

endmodule

// File: tb/tb_rect_rasterizer.sv
`timescale 1ns/1ps
// Scoreboard bench for rect_rasterizer: a frame-buffer RAM model answers the
// read port, a rectangle-level reference model predicts every write, and a
// monitor compares writes, ready and in_progress cycle by cycle.
module tb_rect_rasterizer;

    localparam int HR  = 80;
    localparam int VR  = 60;
    localparam int CD  = 12;
    localparam int ZD  = 2;
    localparam int FBW = CD + ZD;
    localparam int XW  = 7;
    localparam int YW  = 6;
`ifdef RECT_RASTERIZER_ZTEST_EN
    localparam int LAT = 2;
    localparam bit ZT  = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit ZT  = 1'b0;
`endif

    typedef struct {
        int cyc;
        int x;
        int y;
        int data;
    } wr_t;

    logic           clk, srst, cmd_valid, cmd_ready, busy, wr_en;
    logic [XW-1:0]  cmd_x0, cmd_x1, wr_x, rd_x;
    logic [YW-1:0]  cmd_y0, cmd_y1, wr_y, rd_y;
    logic [CD-1:0]  cmd_color;
    logic [ZD-1:0]  cmd_z;
    logic [FBW-1:0] wr_data, rd_data;

    bit [FBW-1:0] mem     [0:HR*VR-1];
    bit [FBW-1:0] ref_mem [0:HR*VR-1];
    bit           busy_exp[0:65535];
    wr_t          exp_q[$];
    int           cyc, rdy_free, wr_count, checks, errors;
    bit           mon_en, poke_en;
    int           poke_idx;
    bit [FBW-1:0] poke_val;

    rect_rasterizer dut (
        .i_clk                 (clk),
        .i_srst                (srst),
        .i_cmd_valid           (cmd_valid),
        .o_cmd_ready           (cmd_ready),
        .i_cmd_x0              (cmd_x0),
        .i_cmd_x1              (cmd_x1),
        .i_cmd_y0              (cmd_y0),
        .i_cmd_y1              (cmd_y1),
        .i_cmd_color           (cmd_color),
        .i_cmd_z               (cmd_z),
        .o_raster_in_progress  (busy),
        .o_fb_horiz_write_addr (wr_x),
        .o_fb_vert_write_addr  (wr_y),
        .o_fb_write_en         (wr_en),
        .o_fb_write_pixel_data (wr_data),
        .o_fb_horiz_read_addr  (rd_x),
        .o_fb_vert_read_addr   (rd_y),
        .i_fb_read_pixel_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer RAM: one-cycle read latency, writes and test pokes
    always @(posedge clk) begin
        int ri, wi;
        ri = int'(rd_y) * HR + int'(rd_x);
        rd_data <= (ri < HR*VR) ? mem[ri] : '0;
        if (wr_en) begin
            wi = int'(wr_y) * HR + int'(wr_x);
            if (wi < HR*VR) mem[wi] = wr_data;
        end
        if (poke_en) mem[poke_idx] = poke_val;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint pk(input int c, input int x, input int y, input int d);
        return (longint'(c) << 32) | (longint'(x) << 24) | (longint'(y) << 16) | longint'(d);
    endfunction

    // Monitor: pops the scoreboard on every write and checks control outputs each cycle
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && !srst) begin
            chk("cmd_ready", longint'(cmd_ready), longint'(cyc >= rdy_free));
            chk("in_progress", longint'(busy), longint'(busy_exp[cyc & 65535]));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missed_write", longint'(cyc), longint'(e.cyc));
            end
            if (wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", pk(cyc, int'(wr_x), int'(wr_y), int'(wr_data)), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", pk(cyc, int'(wr_x), int'(wr_y), int'(wr_data)),
                        pk(e.cyc, e.x, e.y, e.data));
                end
            end else begin
                chk("idle_write_zero", longint'({wr_x, wr_y, wr_data}), 0);
            end
            if (!ZT) chk("read_addr_tied", longint'({rd_x, rd_y}), 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            cmd_x0    = XW'($urandom);
            cmd_x1    = XW'($urandom);
            cmd_y0    = YW'($urandom);
            cmd_y1    = YW'($urandom);
            cmd_color = CD'($urandom);
            cmd_z     = ZD'($urandom);
        end
    endtask

    task automatic poke(input int x, input int y, input int val);
        @(posedge clk); #1;
        poke_en  = 1'b1;
        poke_idx = y * HR + x;
        poke_val = FBW'(val);
        ref_mem[y * HR + x] = FBW'(val);
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Drive one command, wait for acceptance, then push the predicted response
    task automatic send(input int x0, input int x1, input int y0, input int y1,
                        input int color, input int z, output int acc_t);
        int w, x1c, y1c, k, idx, word;
        x0 &= 127; x1 &= 127; y0 &= 63; y1 &= 63; color &= 'hfff; z &= 3;
        @(posedge clk); #1;
        cmd_x0    = XW'(x0);
        cmd_x1    = XW'(x1);
        cmd_y0    = YW'(y0);
        cmd_y1    = YW'(y1);
        cmd_color = CD'(color);
        cmd_z     = ZD'(z);
        cmd_valid = 1'b1;
        w = 0;
        acc_t = -1;
        while (acc_t < 0) begin
            @(negedge clk);
            if (cmd_ready && !srst) begin
                acc_t = cyc;
            end else begin
                w++;
                if (w > 6000) begin
                    chk("accept_timeout", longint'(w), 0);
                    acc_t = cyc;
                    return;
                end
            end
        end
        #1;
        x1c  = (x1 > HR-1) ? HR-1 : x1;
        y1c  = (y1 > VR-1) ? VR-1 : y1;
        word = (z << CD) | color;
        if (x0 > x1c || y0 > y1c) begin
            busy_exp[acc_t+1] = 1'b1;
            rdy_free = acc_t + 1;
        end else begin
            k = 0;
            for (int yy = y0; yy <= y1c; yy++) begin
                for (int xx = x0; xx <= x1c; xx++) begin
                    idx = yy * HR + xx;
                    if (!ZT || z >= int'(ref_mem[idx][FBW-1:CD])) begin
                        exp_q.push_back('{acc_t + LAT + k, xx, yy, word});
                        ref_mem[idx] = FBW'(word);
                    end
                    k++;
                end
            end
            for (int c = acc_t + 1; c <= acc_t + LAT - 1 + k; c++) busy_exp[c] = 1'b1;
            rdy_free = acc_t + LAT + k;
        end
    endtask

    initial begin
        int ta, tb, w0, rx0, rx1, ry0, ry1, tmp;
        checks = 0; errors = 0; wr_count = 0; rdy_free = 0;
        mon_en = 1'b0; poke_en = 1'b0; poke_idx = 0; poke_val = '0;
        srst = 1'b1; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0; cmd_z = '0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        mon_en = 1'b1;

        // Reset in the middle of a 10x10 scan
        send(20, 29, 20, 29, 'h0a5, 1, ta);
        idle(20);
        srst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        srst = 1'b0;
        exp_q.delete();
        for (int c = cyc; c < 65536; c++) busy_exp[c] = 1'b0;
        rdy_free = 0;
        for (int i = 0; i < HR*VR; i++) ref_mem[i] = mem[i];
        @(negedge clk);
        chk("rst_ready", longint'(cmd_ready), 1);
        chk("rst_in_progress", longint'(busy), 0);
        w0 = wr_count;
        idle(15);
        chk("rst_no_write", longint'(wr_count - w0), 0);

        // Single pixel
        w0 = wr_count;
        send(5, 5, 7, 7, 'hf00, 1, ta);
        idle(6);
        chk("single_count", longint'(wr_count - w0), 1);

        // Depth test against prefilled depths 0..3
        for (int i = 0; i < 4; i++) poke(i, 0, (i << CD) | 'h123);
        w0 = wr_count;
        send(0, 3, 0, 0, 'h0f0, 2, ta);
        idle(10);
        chk("ztest_count", longint'(wr_count - w0), ZT ? 3 : 4);

        // Full screen
        w0 = wr_count;
        send(0, 79, 0, 59, 'h00f, 3, ta);
        idle(HR*VR + 8);
        chk("full_count", longint'(wr_count - w0), HR*VR);

        // Clipping and empty command
        w0 = wr_count;
        send(70, 99, 50, 63, 'h555, 3, ta);
        idle(LAT + 104);
        chk("clip_count", longint'(wr_count - w0), 100);
        w0 = wr_count;
        send(10, 5, 0, 3, 'haaa, 3, ta);
        idle(5);
        chk("empty_count", longint'(wr_count - w0), 0);

        // Back-to-back 2x2 commands with valid held high
        w0 = wr_count;
        send(40, 41, 10, 11, 'h111, 3, ta);
        send(50, 51, 30, 31, 'h222, 3, tb);
        chk("b2b_gap", longint'(tb - ta), LAT + 4);
        idle(12);
        chk("b2b_count", longint'(wr_count - w0), 8);

        // Random commands, some out of range or inverted, some back to back
        for (int i = 0; i < 14; i++) begin
            rx0 = $urandom_range(0, 85);
            rx1 = rx0 + $urandom_range(0, 10);
            ry0 = $urandom_range(0, 62);
            ry1 = ry0 + $urandom_range(0, 6);
            if (rx1 > 127) rx1 = 127;
            if (ry1 > 63) ry1 = 63;
            if (i % 5 == 4) begin tmp = rx0; rx0 = rx1 + 1; rx1 = tmp; end
            send(rx0, rx1, ry0, ry1, int'($urandom), int'($urandom_range(0, 3)), ta);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(4);

        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
